cdc_vector_handshake_tx_mux: RTL and testbench

CDC_VECTOR_HANDSHAKE_TX_MUX -- requirements
Module: cdc_vector_handshake_tx_mux

---
 rtl/cdc_pkg.sv | 41 ++++
 rtl/cdc_vector_handshake_tx_mux_sync.sv | 21 ++
 rtl/cdc_vector_handshake_tx_mux.sv | 118 +++++++++++
 tb/tb_cdc_vector_handshake_tx_mux.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the vector handshake transmitter.
// Holds the FSM state encoding and the round-robin channel search.
package cdc_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int IDX_W        = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_grant_t;

  // Scans from last+1 upward (wrapping at channels); the descending loop lets
  // the nearest candidate overwrite farther ones, so no early exit is needed.
  function automatic rr_grant_t rr_arbitrate(input logic [MAX_CHANNELS-1:0] req,
                                             input logic [IDX_W-1:0]        last,
                                             input int                      channels);
    rr_grant_t        g;
    logic [IDX_W:0]   cand;
    g.found = 1'b0;
    g.idx   = '0;
    for (int i = MAX_CHANNELS; i >= 1; i--) begin
      if (i <= channels) begin
        cand = {1'b0, last} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(channels)) cand = cand - (IDX_W+1)'(channels);
        if (req[cand[IDX_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = cand[IDX_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cdc_vector_handshake_tx_mux_sync.sv
// Multi-flop level synchronizer for the far-domain acknowledge.
// All flops clear on reset so the synchronized level starts low.
module cdc_vector_handshake_tx_mux_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_vector_handshake_tx_mux.sv
// Multiplexes several channel vectors onto one four-phase request/acknowledge
// bundle, sending a channel whenever it differs from the value last delivered.
module cdc_vector_handshake_tx_mux
  import cdc_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int CHANNELS    = 4,
  parameter  bit CHANGE_ONLY = 1'b1,
  localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           ack_in,
  output logic                           req_out,
  output logic [CHAN_W-1:0]              chan_out,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [CHANNELS-1:0]            pending,
  output logic                           busy,
  output logic                           done
);

  tx_state_t             state, state_nxt;
  logic                  ack_s;
  logic [DATA_WIDTH-1:0] last_sent [CHANNELS];
  logic [CHANNELS-1:0]   force_set;
  logic [CHAN_W-1:0]     rr_ptr;
  logic [1:0]            warm;
  logic                  sync_ready;
  rr_grant_t             grant;
  logic [CHAN_W-1:0]     grant_chan;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  launch, complete, finish;

  cdc_vector_handshake_tx_mux_sync #(.STAGES(2)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

  // The synchronizer restarts at 0 after reset, so its output only reflects
  // ack_in once two edges have passed; launches wait for that.
  assign sync_ready = (warm == 2'd2);

  always_comb begin
    pending = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pending[k] = CHANGE_ONLY
                 ? ((data_in[k*DATA_WIDTH +: DATA_WIDTH] != last_sent[k]) || force_set[k])
                 : 1'b1;
    end
  end

  assign grant      = rr_arbitrate(MAX_CHANNELS'(pending), IDX_W'(rr_ptr), CHANNELS);
  assign grant_chan = CHAN_W'(grant.idx);
  assign grant_data = data_in[int'(grant_chan)*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    complete  = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_ready && !ack_s && grant.found) begin
          state_nxt = REQ;
          launch    = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_nxt = WAIT_LOW;
          complete  = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_out   <= 1'b0;
      done      <= 1'b0;
      chan_out  <= '0;
      data_out  <= '0;
      force_set <= '1;
      rr_ptr    <= CHAN_W'(CHANNELS-1);
      warm      <= 2'd0;
      for (int k = 0; k < CHANNELS; k++) last_sent[k] <= '0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (!sync_ready) warm <= warm + 2'd1;
      if (launch) begin
        req_out  <= 1'b1;
        chan_out <= grant_chan;
        data_out <= grant_data;
        rr_ptr   <= grant_chan;
      end
      // last_sent takes the captured value, so later input edits stay pending.
      if (complete) begin
        req_out              <= 1'b0;
        last_sent[chan_out]  <= data_out;
        force_set[chan_out]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdc_vector_handshake_tx_mux.sv
// Bench for cdc_vector_handshake_tx_mux: directed scenarios plus random traffic
// scored against a transfer-level model of change detection and round-robin.
module tb_cdc_vector_handshake_tx_mux;

  localparam int DW = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH*DW-1:0] data_in = '0;
  logic          ack_in = 1'b0;
  logic          req_out, busy, done;
  logic [1:0]    chan_out;
  logic [DW-1:0] data_out;
  logic [CH-1:0] pending;

  logic [2*DW-1:0] data_in2 = 16'h5A3C;
  logic          ack_in2 = 1'b0;
  logic          req2, busy2, done2;
  logic [0:0]    chan2;
  logic [DW-1:0] data_out2;
  logic [1:0]    pending2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdc_vector_handshake_tx_mux #(.DATA_WIDTH(DW), .CHANNELS(CH), .CHANGE_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ack_in(ack_in), .req_out(req_out),
    .chan_out(chan_out), .data_out(data_out), .pending(pending), .busy(busy), .done(done));

  cdc_vector_handshake_tx_mux #(.DATA_WIDTH(DW), .CHANNELS(2), .CHANGE_ONLY(1'b0)) dut_cont (
    .clk(clk), .rst(rst), .data_in(data_in2), .ack_in(ack_in2), .req_out(req2),
    .chan_out(chan2), .data_out(data_out2), .pending(pending2), .busy(busy2), .done(done2));

  // Far-side responders: follow req after a delay, or hold a manual level.
  bit   resp_en = 1'b1;
  bit   resp_rand = 1'b0;
  logic ack_man = 1'b0;
  int   resp_cnt = 0;
  int   resp_cur = 2;
  always @(negedge clk) begin
    if (!resp_en) begin
      ack_in   = ack_man;
      resp_cnt = 0;
    end else if (req_out !== ack_in) begin
      resp_cnt++;
      if (resp_cnt >= resp_cur) begin
        ack_in   = req_out;
        resp_cnt = 0;
        resp_cur = resp_rand ? int'($urandom_range(0, 4)) : 2;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (req2 !== ack_in2) ack_in2 = req2;
  end

  // Transfer-level reference model and launch log.
  typedef struct { int chan; int data; int exp_chan; int exp_data; } xfer_t;
  xfer_t log_q[$];
  xfer_t e;
  int    done_cnt = 0;
  int    m_last[CH];
  bit    m_force[CH];
  int    m_ptr;
  int    m_cur_chan = -1;
  int    m_cur_data = -1;
  int    mc;
  logic  req_q = 1'b0;
  logic [CH*DW-1:0] snap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        m_last[k]  = 0;
        m_force[k] = 1'b1;
      end
      m_ptr      = CH - 1;
      m_cur_chan = -1;
      m_cur_data = -1;
      req_q      = 1'b0;
    end else begin
      snap = data_in;
      #1;
      if (req_out === 1'b1 && req_q === 1'b0) begin
        e.exp_chan = -1;
        e.exp_data = -1;
        for (int i = 1; i <= CH; i++) begin
          mc = (m_ptr + i) % CH;
          if (e.exp_chan < 0 && (int'(snap[mc*DW +: DW]) != m_last[mc] || m_force[mc]))
            e.exp_chan = mc;
        end
        if (e.exp_chan >= 0) begin
          e.exp_data = int'(snap[e.exp_chan*DW +: DW]);
          m_ptr      = e.exp_chan;
        end
        e.chan     = int'(chan_out);
        e.data     = int'(data_out);
        m_cur_chan = e.exp_chan;
        m_cur_data = e.exp_data;
        log_q.push_back(e);
      end else if (req_out === 1'b0 && req_q === 1'b1 && m_cur_chan >= 0) begin
        m_last[m_cur_chan]  = m_cur_data;
        m_force[m_cur_chan] = 1'b0;
      end
      if (done === 1'b1) done_cnt++;
      req_q = req_out;
    end
  end

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && pending === '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (chan_out !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d exp 0", chan_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL reset_pending got %h exp f", pending); end
  endtask

  task automatic test_initial_forced();
    bit ok;
    int d0;
    log_q.delete();
    d0  = done_cnt;
    rst = 1'b0;
    wait_quiet(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_quiet got timeout exp idle"); end
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL init_count got %0d exp 4", log_q.size()); end
    foreach (log_q[i]) begin
      checks++;
      if (log_q[i].chan != i || log_q[i].data != 0) begin
        errors++; $display("FAIL init_xfer%0d got ch%0d/%h exp ch%0d/00", i, log_q[i].chan, log_q[i].data, i);
      end
    end
    checks++; if (done_cnt - d0 != 4) begin errors++; $display("FAIL init_done got %0d exp 4", done_cnt - d0); end
    checks++; if (busy !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL init_idle got busy %b pend %h exp 0/0", busy, pending); end
  endtask

  task automatic test_single_change();
    bit ok;
    int d0;
    log_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    data_in[2*DW +: DW] = 8'hA5;
    wait_quiet(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_quiet got timeout exp idle"); end
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", log_q.size()); end
    if (log_q.size() >= 1) begin
      checks++;
      if (log_q[0].chan != 2 || log_q[0].data != 'hA5) begin
        errors++; $display("FAIL single_xfer got ch%0d/%h exp ch2/a5", log_q[0].chan, log_q[0].data);
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_capture_update();
    bit ok;
    log_q.delete();
    @(negedge clk);
    data_in[1*DW +: DW] = 8'h11;
    wait_req(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL capture_req got timeout exp req"); end
    data_in[1*DW +: DW] = 8'h22;
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL capture_held got %h exp 11", data_out); end
    wait_quiet(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL capture_quiet got timeout exp idle"); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL capture_count got %0d exp 2", log_q.size()); end
    if (log_q.size() == 2) begin
      checks++;
      if (log_q[0].chan != 1 || log_q[0].data != 'h11) begin
        errors++; $display("FAIL capture_first got ch%0d/%h exp ch1/11", log_q[0].chan, log_q[0].data);
      end
      checks++;
      if (log_q[1].chan != 1 || log_q[1].data != 'h22) begin
        errors++; $display("FAIL capture_second got ch%0d/%h exp ch1/22", log_q[1].chan, log_q[1].data);
      end
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    @(negedge clk);
    data_in[0 +: DW] = 8'h31;
    wait_quiet(100, ok);
    log_q.delete();
    @(negedge clk);
    data_in[0 +: DW]    = 8'h32;
    data_in[3*DW +: DW] = 8'h33;
    wait_quiet(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_quiet got timeout exp idle"); end
    checks++; if (log_q.size() != 2) begin errors++; $display("FAIL rr_count got %0d exp 2", log_q.size()); end
    if (log_q.size() == 2) begin
      checks++;
      if (log_q[0].chan != 3 || log_q[0].data != 'h33) begin
        errors++; $display("FAIL rr_first got ch%0d/%h exp ch3/33", log_q[0].chan, log_q[0].data);
      end
      checks++;
      if (log_q[1].chan != 0 || log_q[1].data != 'h32) begin
        errors++; $display("FAIL rr_second got ch%0d/%h exp ch0/32", log_q[1].chan, log_q[1].data);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [CH-1:0] exp_p;
    int bad_p = 0;
    int bad_s = 0;
    int k;
    log_q.delete();
    resp_rand = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int j = 0; j < CH; j++)
        exp_p[j] = (int'(data_in[j*DW +: DW]) != m_last[j]) || m_force[j];
      if (pending !== exp_p) bad_p++;
      if (busy === 1'b1 && (int'(chan_out) != m_cur_chan || int'(data_out) != m_cur_data)) bad_s++;
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(0, CH-1));
        data_in[k*DW +: DW] = DW'($urandom);
      end
    end
    resp_rand = 1'b0;
    wait_quiet(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_quiet got timeout exp idle"); end
    checks++; if (bad_p != 0) begin errors++; $display("FAIL rand_pending got %0d bad cycles exp 0", bad_p); end
    checks++; if (bad_s != 0) begin errors++; $display("FAIL rand_stable got %0d bad cycles exp 0", bad_s); end
    checks++; if (log_q.size() < 10) begin errors++; $display("FAIL rand_volume got %0d exp >=10", log_q.size()); end
    foreach (log_q[i]) begin
      checks++;
      if (log_q[i].chan != log_q[i].exp_chan || log_q[i].data != log_q[i].exp_data) begin
        errors++; $display("FAIL rand_xfer%0d got ch%0d/%h exp ch%0d/%h", i, log_q[i].chan,
                           log_q[i].data, log_q[i].exp_chan, log_q[i].exp_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad = 0;
    int n;
    @(negedge clk);
    data_in[1*DW +: DW] = 8'h44;
    wait_req(20, ok);
    resp_en = 1'b0;
    ack_man = 1'b1;
    @(negedge clk);
    #2;
    checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL mid_inreq got %b exp 1", req_out); end
    rst = 1'b1;
    #1;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL mid_req_drop got %b exp 0", req_out); end
    repeat (2) @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (req_out !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || log_q.size() != 0) begin errors++; $display("FAIL mid_blocked got %0d launches exp 0", log_q.size()); end
    #1;
    ack_man = 1'b0;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (req_out === 1'b1) begin ok = 1'b1; break; end
    end
    resp_en = 1'b1;
    checks++; if (!ok || n < 3) begin errors++; $display("FAIL mid_relaunch got %0d cycles exp >=3", n); end
    wait_quiet(200, ok);
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL mid_count got %0d exp 4", log_q.size()); end
    foreach (log_q[i]) begin
      checks++;
      if (log_q[i].chan != i || log_q[i].data != int'(data_in[i*DW +: DW])) begin
        errors++; $display("FAIL mid_xfer%0d got ch%0d/%h exp ch%0d/%h", i, log_q[i].chan,
                           log_q[i].data, i, data_in[i*DW +: DW]);
      end
    end
  endtask

  task automatic test_continuous();
    int rises = 0;
    int prev_chan = -1;
    int bad_alt = 0;
    int bad_gap = 0;
    int bad_dat = 0;
    logic prev_req = 1'b1;
    logic prev_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (req2 === 1'b1 && prev_req === 1'b0) begin
        rises++;
        if (prev_chan >= 0 && int'(chan2) != 1 - prev_chan) bad_alt++;
        if (prev_chan >= 0 && prev_done !== 1'b1) bad_gap++;
        if (data_out2 !== data_in2[int'(chan2)*DW +: DW]) bad_dat++;
        prev_chan = int'(chan2);
      end
      prev_req  = req2;
      prev_done = done2;
    end
    checks++; if (rises < 6) begin errors++; $display("FAIL cont_rate got %0d exp >=6", rises); end
    checks++; if (bad_alt != 0) begin errors++; $display("FAIL cont_alternate got %0d exp 0", bad_alt); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL cont_gap got %0d exp 0", bad_gap); end
    checks++; if (bad_dat != 0) begin errors++; $display("FAIL cont_data got %0d exp 0", bad_dat); end
  endtask

  initial begin
    test_reset();
    test_initial_forced();
    test_single_change();
    test_capture_update();
    test_rr_order();
    test_random();
    test_reset_mid();
    test_continuous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
